// File: rtl/temp_disp_ctrl.sv
// ---------------------------------------------------------------------------
// temp_disp_ctrl
//
// Converts a 6-bit binary temperature into the two decimal digits shown on a
// 4-digit multiplexed display. It also carries a 2-bit system-state code for
// digit 0 and generates the display's digit-scan strobe.
//
// Each accepted sample is clamped to the displayable range 20..59 C. It is
// then split into tens and units by repeated subtraction of 10, one
// subtraction per clock. The display registers change only when a
// conversion has finished, so the display never shows a partial result.
//
// Parameters
//   SCAN_DIV    clk cycles per digit-scan strobe (2 .. 2^20)
//
// Ports
//   clk         system clock, rising-edge active
//   rst         asynchronous active-high reset
//   temp_in     binary temperature 0..63 C
//   temp_valid  temp_in / est_in offered for capture
//   est_in      system-state code for digit 0
//   temp_ready  idle, a sample offered this cycle is accepted
//   uni         units digit 0..9 (bit 4 always 0)
//   dec         tens digit minus 2 (0..3 = 20..59 C)
//   est         registered system-state code
//   range_err   last accepted sample was clamped
//   scan_en     one-cycle strobe advancing the display multiplexer
// ---------------------------------------------------------------------------
module temp_disp_ctrl #(
    parameter int SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] temp_in,
    input  logic       temp_valid,
    input  logic [1:0] est_in,
    output logic       temp_ready,
    output logic [4:0] uni,
    output logic [1:0] dec,
    output logic [1:0] est,
    output logic       range_err,
    output logic       scan_en
);

    // The counter is just wide enough to hold SCAN_DIV-1.
    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

    localparam logic [5:0] TEMP_MIN = 6'd20;
    localparam logic [5:0] TEMP_MAX = 6'd59;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        LOAD = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [5:0]        work;
    logic [2:0]        tens;
    logic [1:0]        est_lat;
    logic              err_cand;
    logic [SCAN_W-1:0] scan_cnt;

    logic       do_capture;
    logic       do_subtract;
    logic       do_update;
    logic [5:0] temp_clamped;
    logic       temp_out_of_range;

    // Clamp is purely combinational, so the value loaded at capture is
    // already in range. After clamping, work stays below 60 and tens stays
    // below 6, which fit in 6 and 3 bits.
    always_comb begin
        temp_clamped      = temp_in;
        temp_out_of_range = 1'b0;
        if (temp_in < TEMP_MIN) begin
            temp_clamped      = TEMP_MIN;
            temp_out_of_range = 1'b1;
        end else if (temp_in > TEMP_MAX) begin
            temp_clamped      = TEMP_MAX;
            temp_out_of_range = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and datapath strobes. temp_ready is a Moore output,
    // so a sample offered while busy is simply not seen.
    always_comb begin
        state_next  = state;
        temp_ready  = 1'b0;
        do_capture  = 1'b0;
        do_subtract = 1'b0;
        do_update   = 1'b0;
        case (state)
            IDLE: begin
                temp_ready = 1'b1;
                if (temp_valid) begin
                    do_capture = 1'b1;
                    state_next = CONV;
                end
            end
            CONV: begin
                if (work >= 6'd10) begin
                    do_subtract = 1'b1;
                end else begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                do_update  = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Conversion working registers. These are kept apart from the display
    // registers so that intermediate values never reach the outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            work     <= '0;
            tens     <= '0;
            est_lat  <= '0;
            err_cand <= 1'b0;
        end else if (do_capture) begin
            work     <= temp_clamped;
            tens     <= '0;
            est_lat  <= est_in;
            err_cand <= temp_out_of_range;
        end else if (do_subtract) begin
            work <= work - 6'd10;
            tens <= tens + 3'd1;
        end
    end

    // Display registers. They update together on the LOAD exit edge and
    // hold otherwise. dec is the tens digit minus 2. Doing this subtraction
    // in 2 bits gives the same result as doing it in 3 bits, because tens
    // is always 2..5 here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            uni       <= '0;
            dec       <= '0;
            est       <= '0;
            range_err <= 1'b0;
        end else if (do_update) begin
            uni       <= {1'b0, work[3:0]};
            dec       <= tens[1:0] - 2'd2;
            est       <= est_lat;
            range_err <= err_cand;
        end
    end

    // Free-running scan divider, independent of the conversion FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt <= '0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    // The strobe is decoded from the counter. Because the counter is 0
    // during reset and SCAN_DIV is at least 2, the strobe is low during
    // reset. Its first pulse comes SCAN_DIV cycles after reset is released.
    assign scan_en = (scan_cnt == SCAN_LAST);

endmodule

// File: tb/tb_temp_disp_ctrl.sv
// ---------------------------------------------------------------------------
// tb_temp_disp_ctrl
//
// Directed bench for temp_disp_ctrl, using SCAN_DIV = 4. Expected digits,
// latencies and scan strobe positions are worked out by hand from the
// decimal value of each sample.
// ---------------------------------------------------------------------------
module tb_temp_disp_ctrl;

    localparam int SCAN_DIV = 4;

    logic       clk;
    logic       rst;
    logic [5:0] temp_in;
    logic       temp_valid;
    logic [1:0] est_in;
    logic       temp_ready;
    logic [4:0] uni;
    logic [1:0] dec;
    logic [1:0] est;
    logic       range_err;
    logic       scan_en;

    int vectors;
    int miscompares;
    int scan_phase;

    // Displayed values the bench expects the DUT to be holding.
    logic [4:0] cur_uni;
    logic [1:0] cur_dec;
    logic [1:0] cur_est;
    logic       cur_err;

    temp_disp_ctrl #(
        .SCAN_DIV(SCAN_DIV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .temp_in   (temp_in),
        .temp_valid(temp_valid),
        .est_in    (est_in),
        .temp_ready(temp_ready),
        .uni       (uni),
        .dec       (dec),
        .est       (est),
        .range_err (range_err),
        .scan_en   (scan_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Advance one clock edge, then sample 1 ns later. The scan strobe is
    // checked after every edge against the bench's own phase count.
    task automatic tick();
        @(posedge clk);
        #1;
        if (!rst) scan_phase = (scan_phase + 1) % SCAN_DIV;
        checkOutput("scan_en", {7'd0, scan_en},
                    {7'd0, (scan_phase == SCAN_DIV - 1)});
    endtask

    task automatic checkHeld(input string tag);
        checkOutput({tag, "_uni_hold"}, {3'd0, uni}, {3'd0, cur_uni});
        checkOutput({tag, "_dec_hold"}, {6'd0, dec}, {6'd0, cur_dec});
        checkOutput({tag, "_est_hold"}, {6'd0, est}, {6'd0, cur_est});
        checkOutput({tag, "_err_hold"}, {7'd0, range_err}, {7'd0, cur_err});
    endtask

    task automatic checkDisplay(input string tag, input logic [4:0] e_uni,
                                input logic [1:0] e_dec, input logic [1:0] e_est,
                                input logic e_err);
        checkOutput({tag, "_uni"}, {3'd0, uni}, {3'd0, e_uni});
        checkOutput({tag, "_dec"}, {6'd0, dec}, {6'd0, e_dec});
        checkOutput({tag, "_est"}, {6'd0, est}, {6'd0, e_est});
        checkOutput({tag, "_err"}, {7'd0, range_err}, {7'd0, e_err});
        cur_uni = e_uni;
        cur_dec = e_dec;
        cur_est = e_est;
        cur_err = e_err;
    endtask

    // One valid-pulse transaction. The capture happens at edge T, the
    // display must hold through T+n+1, and the new value appears at T+n+2.
    task automatic applyStimulus(input string tag, input logic [5:0] t,
                                 input logic [1:0] e, input logic [4:0] e_uni,
                                 input logic [1:0] e_dec, input logic e_err,
                                 input int n);
        checkOutput({tag, "_ready_idle"}, {7'd0, temp_ready}, 8'd1);
        temp_in    = t;
        est_in     = e;
        temp_valid = 1'b1;
        tick();
        temp_valid = 1'b0;
        for (int i = 0; i <= n; i++) begin
            checkOutput({tag, "_ready_busy"}, {7'd0, temp_ready}, 8'd0);
            checkHeld(tag);
            tick();
        end
        checkOutput({tag, "_ready_busy"}, {7'd0, temp_ready}, 8'd0);
        checkHeld(tag);
        tick();
        checkDisplay(tag, e_uni, e_dec, e, e_err);
        checkOutput({tag, "_ready_done"}, {7'd0, temp_ready}, 8'd1);
    endtask

    initial begin
        logic [5:0] garbage [6];
        vectors     = 0;
        miscompares = 0;
        scan_phase  = 0;
        cur_uni     = '0;
        cur_dec     = '0;
        cur_est     = '0;
        cur_err     = 1'b0;
        garbage[0]  = 6'd63;
        garbage[1]  = 6'd0;
        garbage[2]  = 6'd55;
        garbage[3]  = 6'd12;
        garbage[4]  = 6'd33;
        garbage[5]  = 6'd50;

        rst        = 1'b1;
        temp_in    = '0;
        temp_valid = 1'b0;
        est_in     = '0;

        // Reset state, held over a few edges.
        tick();
        tick();
        checkDisplay("reset", 5'd0, 2'd0, 2'd0, 1'b0);
        checkOutput("reset_ready", {7'd0, temp_ready}, 8'd1);
        checkOutput("reset_scan", {7'd0, scan_en}, 8'd0);

        // Release 1 ns after an edge. The next edge is cycle 1, so strobes
        // follow edges 3, 7, 11, ...
        rst = 1'b0;
        for (int i = 0; i < 12; i++) tick();

        // Normal conversion: 37 -> 3 subtractions.
        applyStimulus("s37", 6'd37, 2'd2, 5'd7, 2'd1, 1'b0, 3);
        // High clamp, then an in-range sample clears range_err.
        applyStimulus("s63", 6'd63, 2'd1, 5'd9, 2'd3, 1'b1, 5);
        applyStimulus("s25", 6'd25, 2'd3, 5'd5, 2'd0, 1'b0, 2);
        // Low clamp and exact boundaries.
        applyStimulus("s05", 6'd5,  2'd0, 5'd0, 2'd0, 1'b1, 2);
        applyStimulus("s20", 6'd20, 2'd2, 5'd0, 2'd0, 1'b0, 2);
        applyStimulus("s59", 6'd59, 2'd1, 5'd9, 2'd3, 1'b0, 5);

        // Busy: valid held high while temp_in changes every cycle.
        // Capture 42 (4 subtractions, update at T+6), then 31 at T+7.
        temp_valid = 1'b1;
        temp_in    = 6'd42;
        est_in     = 2'd1;
        checkOutput("busy_ready0", {7'd0, temp_ready}, 8'd1);
        tick();
        for (int i = 0; i < 6; i++) begin
            temp_in = garbage[i];
            est_in  = 2'(i);
            checkOutput("busy_ready_a", {7'd0, temp_ready}, 8'd0);
            checkHeld("busy_a");
            tick();
        end
        checkDisplay("busy42", 5'd2, 2'd2, 2'd1, 1'b0);
        checkOutput("busy_ready1", {7'd0, temp_ready}, 8'd1);
        temp_in = 6'd31;
        est_in  = 2'd3;
        tick();
        for (int i = 0; i < 5; i++) begin
            temp_in = garbage[5 - i];
            est_in  = 2'(i);
            checkOutput("busy_ready_b", {7'd0, temp_ready}, 8'd0);
            checkHeld("busy_b");
            tick();
        end
        checkDisplay("busy31", 5'd1, 2'd1, 2'd3, 1'b0);
        temp_valid = 1'b0;
        tick();
        checkHeld("busy_after");

        // Reset two cycles after capturing 48. It must clear the outputs
        // immediately, and 48 must never appear.
        temp_in    = 6'd48;
        est_in     = 2'd2;
        temp_valid = 1'b1;
        tick();
        temp_valid = 1'b0;
        tick();
        tick();
        rst        = 1'b1;
        scan_phase = 0;
        #1;
        checkDisplay("rst_mid", 5'd0, 2'd0, 2'd0, 1'b0);
        checkOutput("rst_mid_ready", {7'd0, temp_ready}, 8'd1);
        checkOutput("rst_mid_scan", {7'd0, scan_en}, 8'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            checkHeld("rst_after");
            checkOutput("rst_after_ready", {7'd0, temp_ready}, 8'd1);
        end

        // Normal operation after the abort.
        applyStimulus("s44", 6'd44, 2'd3, 5'd4, 2'd2, 1'b0, 4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/temp_disp_ctrl.md
TEMP_DISP_CTRL -- requirements
Module: temp_disp_ctrl

Interface
REQ-001 Parameter SCAN_DIV, default 50000; meaning: clk cycles per digit-scan strobe (legal range 2..2^20).
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 temp_in  input  6  binary temperature in degrees C, unsigned 0..63.
REQ-005 temp_valid  input  1  temp_in and est_in are offered for capture this cycle.
REQ-006 est_in  input  2  system-state code to show on digit 0.
REQ-007 temp_ready  output  1  block is idle and accepts temp_valid this cycle.
REQ-008 uni  output  5  units digit of displayed temperature, values 0..9; bit 4 always 0.
REQ-009 dec  output  2  tens digit minus 2; 0..3 encodes 20..59 C.
REQ-010 est  output  2  registered system-state code for the display.
REQ-011 range_err  output  1  last accepted sample was outside 20..59 and was clamped.
REQ-012 scan_en  output  1  one-cycle strobe that advances the 4-digit display multiplexer.

Function
REQ-013 Control FSM SHALL have exactly three states: IDLE, CONV, LOAD.
REQ-014 temp_ready SHALL be 1 in IDLE only, as a Moore output.
REQ-015 Handshake: capture occurs on an edge where state=IDLE and temp_valid=1; temp_valid in any other state SHALL be ignored.
REQ-016 At capture: clamp temp_in to 20 if below 20, or to 59 if above 59, then load the work register; latch est_in; set the range_err candidate to 1 if clamped, else 0; clear the tens counter; go to CONV.
REQ-017 CONV, each cycle: if work>=10, then work<=work-10 and tens<=tens+1, staying in CONV; otherwise go to LOAD with no arithmetic.
REQ-018 LOAD: on its exit edge, update uni<=work, dec<=tens-2 (2-bit), est<=latched est_in, and range_err<=candidate; go to IDLE.
REQ-019 Latency: with capture at edge T and tens digit N (2..5), outputs SHALL update at edge T+N+2; temp_ready SHALL be 0 from after edge T until after edge T+N+2.
REQ-020 uni, dec, est and range_err SHALL hold their values between LOAD updates and SHALL never show partial results.
REQ-021 Work register SHALL be 6 bits and tens counter 3 bits; no overflow is possible after clamping.
REQ-022 Scan counter: free-running, 0..SCAN_DIV-1, wrapping to 0; it SHALL be independent of FSM state.
REQ-023 scan_en SHALL be 1 exactly in the cycle the counter equals SCAN_DIV-1, giving a period of SCAN_DIV cycles.
REQ-024 Boundaries: input 20 gives uni=0, dec=0; input 59 gives uni=9, dec=3; neither sets range_err.

Reset
REQ-025 While rst=1: state=IDLE, temp_ready=1, uni=0, dec=0, est=0, range_err=0, scan counter=0, scan_en=0, and work, tens and latches are cleared.
REQ-026 Reset asserted mid-CONV or mid-LOAD SHALL abort the conversion; no output update occurs, and all outputs take reset values immediately (asynchronous).
REQ-027 After rst deasserts, the first scan_en SHALL occur in the SCAN_DIV-th cycle.

Verification
REQ-028 Normal: temp_in=37, est_in=2, temp_valid pulse at T -> at T+5: uni=7, dec=1, est=2, range_err=0; temp_ready low T+1..T+5.
REQ-029 Clamp: temp_in=63 -> uni=9, dec=3, range_err=1; next sample 25 -> uni=5, dec=0, range_err=0.
REQ-030 Low clamp/edges: temp_in=5 -> uni=0, dec=0, range_err=1; temp_in=20 and temp_in=59 -> exact boundary values, range_err=0.
REQ-031 Busy: with temp_valid held high continuously and temp_in changing each cycle -> only values present at IDLE edges are captured; outputs are never corrupted mid-conversion.
REQ-032 Reset mid-op: rst asserted two cycles after capturing 48 -> outputs 0, temp_ready=1, no later update of 48.
REQ-033 Scan: SCAN_DIV=4 -> scan_en is high on cycles 4, 8, 12 after reset release, uninterrupted during conversions.
